// File: rtl/sync_generator.sv
`timescale 1ns/1ps
// sync_generator: video timing counters with registered, mutually aligned enables and syncs.
module sync_generator #(
  parameter int H_RES   = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_RES   = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [3:0]  pc_ena,
  output logic        hde,
  output logic        vde,
  output logic        hs,
  output logic        vs,
  output logic [11:0] h_count,
  output logic [11:0] v_count,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);
  localparam int H_TOTAL = H_RES + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_RES + V_FRONT + V_SYNC + V_BACK;
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("sync_generator: H_TOTAL and V_TOTAL must not exceed 4096");
  end
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_DE = 13'(H_RES);
  localparam logic [12:0] H_SS = 13'(H_RES + H_FRONT);
  localparam logic [12:0] H_SE = 13'(H_RES + H_FRONT + H_SYNC);
  localparam logic [12:0] V_DE = 13'(V_RES);
  localparam logic [12:0] V_SS = 13'(V_RES + V_FRONT);
  localparam logic [12:0] V_SE = 13'(V_RES + V_FRONT + V_SYNC);
  logic        tick, h_wrap, fs_next;
  logic [11:0] h_next, v_next;
  logic [12:0] hx, vx;
  // Decodes use next-count values so flags land on the same tick as the counters.
  always_comb begin
    tick    = pc_ena == 4'd0;
    h_wrap  = h_count == H_LAST;
    h_next  = h_wrap ? 12'd0 : h_count + 12'd1;
    v_next  = h_wrap ? (v_count == V_LAST ? 12'd0 : v_count + 12'd1) : v_count;
    hx      = {1'b0, h_next};
    vx      = {1'b0, v_next};
    fs_next = h_next == 12'd0 && v_next == 12'd0;
  end
  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      h_count     <= H_LAST;
      v_count     <= V_LAST;
      hde         <= 1'b0;
      vde         <= 1'b0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'hFF;
    end else if (tick) begin
      h_count     <= h_next;
      v_count     <= v_next;
      hde         <= hx < H_DE;
      vde         <= vx < V_DE;
      hs          <= hx >= H_SS && hx < H_SE;
      vs          <= vx >= V_SS && vx < V_SE;
      line_start  <= h_next == 12'd0;
      frame_start <= fs_next;
      frame_cnt   <= frame_cnt + {7'd0, fs_next};
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
endmodule

// File: tb/tb_sync_generator.sv
`timescale 1ns/1ps
// tb_sync_generator: directed checks of sync_generator timing against a small counter model.
module tb_sync_generator;
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  int n_chk = 0, n_pass = 0;

  logic d_rst, d_hde, d_vde, d_hs, d_vs, d_ls, d_fs;
  logic [3:0] d_ena;
  logic [11:0] d_h, d_v;
  logic [7:0] d_fc;
  sync_generator u_d (.pclk(pclk), .reset(d_rst), .pc_ena(d_ena), .hde(d_hde), .vde(d_vde),
    .hs(d_hs), .vs(d_vs), .h_count(d_h), .v_count(d_v), .line_start(d_ls),
    .frame_start(d_fs), .frame_cnt(d_fc));

  logic m_rst, m_hde, m_vde, m_hs, m_vs, m_ls, m_fs;
  logic [3:0] m_ena;
  logic [11:0] m_h, m_v;
  logic [7:0] m_fc;
  sync_generator #(.H_RES(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)) u_m (.pclk(pclk),
    .reset(m_rst), .pc_ena(m_ena), .hde(m_hde), .vde(m_vde), .hs(m_hs), .vs(m_vs),
    .h_count(m_h), .v_count(m_v), .line_start(m_ls), .frame_start(m_fs), .frame_cnt(m_fc));

  logic s_rst, s_hde, s_vde, s_hs, s_vs, s_ls, s_fs;
  logic [3:0] s_ena;
  logic [11:0] s_h, s_v;
  logic [7:0] s_fc;
  sync_generator #(.H_RES(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1), .V_RES(3), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1)) u_s (.pclk(pclk), .reset(s_rst), .pc_ena(s_ena), .hde(s_hde),
    .vde(s_vde), .hs(s_hs), .vs(s_vs), .h_count(s_h), .v_count(s_v), .line_start(s_ls),
    .frame_start(s_fs), .frame_cnt(s_fc));

  logic r_rst, r_hde, r_vde, r_hs, r_vs, r_ls, r_fs;
  logic [3:0] r_ena;
  logic [11:0] r_h, r_v;
  logic [7:0] r_fc;
  sync_generator #(.H_RES(301), .H_FRONT(1), .H_SYNC(1), .H_BACK(1), .V_RES(201), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1)) u_r (.pclk(pclk), .reset(r_rst), .pc_ena(r_ena), .hde(r_hde),
    .vde(r_vde), .hs(r_hs), .vs(r_vs), .h_count(r_h), .v_count(r_v), .line_start(r_ls),
    .frame_start(r_fs), .frame_cnt(r_fc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mh, mv, mfc, bad_cnt, bad_de, bad_hs, bad_vs, bad_ls, bad_fs, bad_fc;
    int ls_n, hs_n, hs_min, hs_max, vs_lines, w;
    int ls_t[2];
    int fs_t[3];
    d_rst = 1; m_rst = 1; s_rst = 1; r_rst = 1;
    d_ena = 4'd1; m_ena = 4'd0; s_ena = 4'd0; r_ena = 4'd0;
    repeat (3) step;
    check("rst_h", d_h, 799);
    check("rst_v", d_v, 524);
    check("rst_flags", {d_hde, d_vde, d_hs, d_vs, d_ls, d_fs}, 0);
    check("rst_fc", d_fc, 8'hFF);
    // first tick after release
    r_rst = 0;
    d_rst = 0;
    d_ena = 4'd0;
    step;
    check("first_h", d_h, 0);
    check("first_v", d_v, 0);
    check("first_de", {d_hde, d_vde}, 2'b11);
    check("first_pulses", {d_ls, d_fs}, 2'b11);
    check("first_fc", d_fc, 0);
    d_ena = 4'd1;
    step;
    check("pulse_drop", {d_ls, d_fs}, 2'b00);
    check("hold_h", d_h, 0);
    // pc_ena cycling 0..3 over two lines
    mh = 0; mv = 0; bad_cnt = 0; bad_de = 0; bad_hs = 0; bad_ls = 0;
    ls_n = 0; hs_n = 0; hs_min = 4095; hs_max = 0;
    for (int c = 1; c <= 6402; c++) begin
      d_ena = 4'(c % 4);
      step;
      if (c % 4 == 0) begin
        mh = (mh == 799) ? 0 : mh + 1;
        if (mh == 0) mv = (mv == 524) ? 0 : mv + 1;
      end
      if (d_h != 12'(mh) || d_v != 12'(mv)) bad_cnt++;
      if (d_hde != (mh < 640)) bad_de++;
      if (d_hs != (mh >= 656 && mh < 752)) bad_hs++;
      if (d_ls != (c % 4 == 0 && mh == 0)) bad_ls++;
      if (d_ls) begin
        if (ls_n < 2) ls_t[ls_n] = c;
        ls_n++;
      end
      if (d_hs && c % 4 == 0) begin
        hs_n++;
        if (int'(d_h) < hs_min) hs_min = int'(d_h);
        if (int'(d_h) > hs_max) hs_max = int'(d_h);
      end
    end
    check("line_counters", bad_cnt, 0);
    check("line_hde", bad_de, 0);
    check("line_hs", bad_hs, 0);
    check("line_ls", bad_ls, 0);
    check("ls_count", ls_n, 2);
    check("ls_first_at", ls_t[0], 3200);
    check("ls_second_at", ls_t[1], 6400);
    check("hs_ticks", hs_n, 192);
    check("hs_first_col", hs_min, 656);
    check("hs_last_col", hs_max, 751);
    // freeze mid-line with pc_ena = 5
    d_ena = 4'd0;
    repeat (100) step;
    check("pre_freeze_h", d_h, 100);
    d_ena = 4'd5;
    bad_cnt = 0;
    repeat (100) begin
      step;
      if (d_h != 12'd100 || d_v != 12'd2 || {d_hde, d_vde, d_hs, d_vs, d_ls, d_fs} != 6'b110000)
        bad_cnt++;
    end
    check("freeze", bad_cnt, 0);
    check("freeze_fc", d_fc, 0);
    // full frame: default vertical timing, short lines
    m_rst = 0;
    mh = 10; mv = 524; bad_cnt = 0; bad_de = 0; bad_vs = 0; vs_lines = 0; ls_n = 0;
    for (int c = 1; c <= 11552; c++) begin
      step;
      mh = (mh == 10) ? 0 : mh + 1;
      if (mh == 0) mv = (mv == 524) ? 0 : mv + 1;
      if (m_h != 12'(mh) || m_v != 12'(mv)) bad_cnt++;
      if (m_vde != (mv < 480)) bad_de++;
      if (m_vs != (mv >= 490 && mv < 492)) bad_vs++;
      if (m_vs && mh == 0) vs_lines++;
      if (m_fs) begin
        if (ls_n < 3) fs_t[ls_n] = c;
        ls_n++;
      end
    end
    check("frame_counters", bad_cnt, 0);
    check("frame_vde", bad_de, 0);
    check("frame_vs", bad_vs, 0);
    check("frame_vs_lines", vs_lines, 4);
    check("fs_count", ls_n, 3);
    check("fs_second_at", fs_t[1], 5776);
    check("fs_third_at", fs_t[2], 11551);
    check("frame_fc", m_fc, 2);
    // 256 tiny frames: frame_cnt wrap and sync positions
    s_rst = 0;
    mh = 6; mv = 5; mfc = 255; bad_hs = 0; bad_vs = 0; bad_fs = 0; bad_fc = 0;
    for (int c = 1; c <= 10753; c++) begin
      step;
      mh = (mh == 6) ? 0 : mh + 1;
      if (mh == 0) mv = (mv == 5) ? 0 : mv + 1;
      if (mh == 0 && mv == 0) mfc = (mfc + 1) % 256;
      if (s_hs != (mh == 5)) bad_hs++;
      if (s_vs != (mv == 4)) bad_vs++;
      if (s_fs != (mh == 0 && mv == 0)) bad_fs++;
      if (s_fc != 8'(mfc)) bad_fc++;
      if (c == 1 + 42 * 255) check("small_fc_255", s_fc, 255);
    end
    check("small_hs", bad_hs, 0);
    check("small_vs", bad_vs, 0);
    check("small_fs", bad_fs, 0);
    check("small_fc_track", bad_fc, 0);
    check("small_fc_wrap", s_fc, 0);
    check("small_fs_at_wrap", s_fs, 1);
    // asynchronous reset mid-frame
    w = 0;
    while (!(r_h == 12'd300 && r_v == 12'd200) && w < 70000) begin
      step;
      w++;
    end
    check("r_reach_target", w < 70000, 1);
    check("r_pre_de", {r_hde, r_vde}, 2'b11);
    #3 r_rst = 1;
    #1;
    check("r_async_h", r_h, 303);
    check("r_async_v", r_v, 203);
    check("r_async_flags", {r_hde, r_vde, r_hs, r_vs, r_ls, r_fs}, 0);
    check("r_async_fc", r_fc, 8'hFF);
    #1 r_rst = 0;
    step;
    check("r_restart_hv", {r_h, r_v}, 0);
    check("r_restart_de", {r_hde, r_vde}, 2'b11);
    check("r_restart_pulses", {r_ls, r_fs}, 2'b11);
    check("r_restart_fc", r_fc, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_generator.md
SYNC_GENERATOR -- requirements
Module: sync_generator

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, meaning vertical sync width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-009 SHALL have port pclk, input, 1 bit, meaning pixel-domain clock; the block has one clock.
REQ-010 SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-011 SHALL have port pc_ena, input, 4 bits, meaning pixel clock-enable phase; a pixel tick is any pclk edge with pc_ena == 0.
REQ-012 SHALL have port hde, output, 1 bit, meaning horizontal display enable, high in the active pixel region.
REQ-013 SHALL have port vde, output, 1 bit, meaning vertical display enable, high in the active line region.
REQ-014 SHALL have port hs, output, 1 bit, meaning horizontal sync, active high; polarity inversion belongs to the output stage.
REQ-015 SHALL have port vs, output, 1 bit, meaning vertical sync, active high.
REQ-016 SHALL have port h_count, output, 12 bits, meaning current pixel column.
REQ-017 SHALL have port v_count, output, 12 bits, meaning current line.
REQ-018 SHALL have port line_start, output, 1 bit, meaning one-pclk pulse on the tick where h_count becomes 0.
REQ-019 SHALL have port frame_start, output, 1 bit, meaning one-pclk pulse on the tick where h_count and v_count both become 0.
REQ-020 SHALL have port frame_cnt, output, 8 bits, meaning frame counter.

Function
REQ-021 SHALL define H_TOTAL = H_RES+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_RES+V_FRONT+V_SYNC+V_BACK; both SHALL be ≤ 4096, and an elaboration-time check SHALL reject violations.
REQ-022 SHALL hold every register unchanged on pclk edges where pc_ena != 0, except that line_start and frame_start SHALL drop to 0.
REQ-023 On each pixel tick, h_count SHALL increment, and it SHALL wrap from H_TOTAL-1 to 0.
REQ-024 On a tick where h_count wraps, v_count SHALL increment, and it SHALL wrap from V_TOTAL-1 to 0; otherwise v_count SHALL hold.
REQ-025 hde, vde, hs and vs SHALL be registered and SHALL be computed from the counter values loaded on the same tick, so that all outputs are mutually aligned with zero relative latency.
REQ-026 hde SHALL be 1 iff h_count < H_RES.
REQ-027 vde SHALL be 1 iff v_count < V_RES.
REQ-028 hs SHALL be 1 iff H_RES+H_FRONT ≤ h_count < H_RES+H_FRONT+H_SYNC.
REQ-029 vs SHALL be 1 iff V_RES+V_FRONT ≤ v_count < V_RES+V_FRONT+V_SYNC; vs SHALL change only on ticks where h_count becomes 0.
REQ-030 line_start SHALL be 1 for exactly the pclk cycle following a tick that loads h_count = 0.
REQ-031 frame_start SHALL be 1 for exactly the pclk cycle following a tick that loads h_count = 0 and v_count = 0.
REQ-032 frame_cnt SHALL increment modulo 256 on every tick that asserts frame_start, and it SHALL wrap from 255 to 0.
REQ-033 Adjacent pixel ticks (pc_ena == 0 on consecutive edges) SHALL advance the counters on every edge with no lost or duplicated counts.

Reset
REQ-034 While reset is high, the block SHALL asynchronously force h_count = H_TOTAL-1 and v_count = V_TOTAL-1.
REQ-035 While reset is high, the block SHALL asynchronously force hde, vde, hs, vs, line_start and frame_start to 0, and frame_cnt to 8'hFF.
REQ-036 The first pixel tick after reset release SHALL load h_count = 0 and v_count = 0, and set hde = vde = 1, line_start = frame_start = 1 and frame_cnt = 0.
REQ-037 Reset asserted mid-frame SHALL take effect immediately, without waiting for pclk or pc_ena, and the frame SHALL restart per REQ-036.

Verification
REQ-038 The bench SHALL check reset release, then pc_ena = 0 on the next edge -> h_count = 0, v_count = 0, hde = vde = 1, frame_start = line_start = 1 for one pclk, and frame_cnt = 0.
REQ-039 The bench SHALL check pc_ena cycling 0..3 with defaults -> hde high for ticks with h_count 0..639, hs high for h_count 656..751, a line period of 800 ticks (3200 pclk), and line_start every 3200 pclk.
REQ-040 The bench SHALL check a full frame with defaults -> vs high exactly for v_count 490..491, vde low for v_count 480..524, and frame_start every 420000 ticks.
REQ-041 The bench SHALL check pc_ena held at 5 for 100 pclk mid-line -> all counters and hde/vde/hs/vs frozen, and line_start/frame_start stay 0.
REQ-042 The bench SHALL check reset pulsed asynchronously (between pclk edges) at h_count = 300, v_count = 200 -> outputs cleared before the next pclk edge, and the next tick behaves per REQ-038.
REQ-043 The bench SHALL check 256 frames run with small parameters (H 4/1/1/1, V 3/1/1/1) -> frame_cnt wraps from 255 to 0, and hs/vs positions are correct at totals of 7 and 6.
